// File: rtl/cpu_defs.sv
// Shared decode types and encodings for the fetch-to-issue decode queue.
package cpu_defs;

    typedef logic [4:0] RegAddr_t;

    typedef enum logic [4:0] {
        OP_NOP,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOR,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO,
        OP_MOVN,
        OP_MOVZ,
        OP_JR,
        OP_JALR,
        OP_MADDU,
        OP_MFC0,
        OP_MTC0,
        OP_ERET,
        OP_INVALID
    } Oper_t;

    // Primary opcodes
    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OPC_COP0     = 6'h10;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MOVN  = 6'h0B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;

    // SPECIAL2 funct codes
    localparam logic [5:0] FN_MADDU = 6'h01;

    // COP0 rs-field codes and the CO-group funct for ERET
    localparam logic [4:0] RS_MF    = 5'h00;
    localparam logic [4:0] RS_MT    = 5'h04;
    localparam logic [4:0] RS_CO    = 5'h10;
    localparam logic [5:0] FN_ERET  = 6'h18;

    typedef struct packed {
        Oper_t       op;
        RegAddr_t    raddr1;
        RegAddr_t    raddr2;
        RegAddr_t    waddr;
        logic        we;
        logic [31:0] pc;
    } DecodedInst_t;

    // Ops that change machine state in ways later instructions depend on
    // (or cannot be executed at all) must leave the queue on their own.
    function automatic logic is_serialising(input Oper_t op);
        return (op == OP_MTC0) || (op == OP_ERET) || (op == OP_INVALID);
    endfunction

endpackage

// File: rtl/id_decode_one.sv
// Combinational decoder for one fetched instruction word.
module id_decode_one
    import cpu_defs::*;
(
    input  logic [31:0]  inst,
    input  logic [31:0]  pc,
    output DecodedInst_t dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    RegAddr_t   rs;
    RegAddr_t   rt;
    RegAddr_t   rd;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign funct  = inst[5:0];

    // Map opcode/funct/rs to an op and override the default register fields.
    always_comb begin
        // NOTE: every field gets a default before any branch so no path can infer a latch.
        dec.op     = OP_INVALID;
        dec.raddr1 = rs;
        dec.raddr2 = rt;
        dec.waddr  = rd;
        dec.we     = 1'b1;
        dec.pc     = pc;

        if (inst == 32'h0) begin
            dec.op     = OP_NOP;
            dec.we     = 1'b0;
            dec.raddr1 = '0;
            dec.raddr2 = '0;
        end else begin
            case (opcode)
                OPC_SPECIAL: begin
                    case (funct)
                        FN_AND:  dec.op = OP_AND;
                        FN_OR:   dec.op = OP_OR;
                        FN_XOR:  dec.op = OP_XOR;
                        FN_NOR:  dec.op = OP_NOR;
                        FN_MFHI: dec.op = OP_MFHI;
                        FN_MFLO: dec.op = OP_MFLO;
                        FN_MTHI: begin dec.op = OP_MTHI; dec.we = 1'b0; end
                        FN_MTLO: begin dec.op = OP_MTLO; dec.we = 1'b0; end
                        FN_MOVN: dec.op = OP_MOVN;
                        FN_MOVZ: dec.op = OP_MOVZ;
                        FN_JR:   begin dec.op = OP_JR;   dec.we = 1'b0; end
                        FN_JALR: dec.op = OP_JALR;
                        default: dec.op = OP_INVALID;
                    endcase
                end
                OPC_SPECIAL2: begin
                    if (funct == FN_MADDU) begin
                        dec.op = OP_MADDU;
                        dec.we = 1'b0;
                    end
                end
                OPC_COP0: begin
                    if (rs == RS_MF) begin
                        dec.op     = OP_MFC0;
                        dec.waddr  = rt;
                        dec.raddr1 = '0;
                        dec.raddr2 = '0;
                    end else if (rs == RS_MT) begin
                        dec.op     = OP_MTC0;
                        dec.we     = 1'b0;
                        dec.raddr1 = '0;
                    end else if (rs == RS_CO && funct == FN_ERET) begin
                        dec.op     = OP_ERET;
                        dec.we     = 1'b0;
                        dec.raddr1 = '0;
                    end
                end
                default: dec.op = OP_INVALID;
            endcase
        end
    end

endmodule

// File: rtl/id_decode_queue.sv
// Multi-way decode stage: decodes fetched instructions into an in-order
// circular queue and presents up to ISSUE_WIDTH entries from its head.
module id_decode_queue
    import cpu_defs::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [FETCH_WIDTH-1:0]                 fetch_valid,
    input  logic [FETCH_WIDTH-1:0][31:0]           fetch_inst,
    input  logic [FETCH_WIDTH-1:0][31:0]           fetch_pc,
    output logic                                   fetch_ready,
    output logic [ISSUE_WIDTH-1:0]                 issue_valid,
    output Oper_t                                  issue_op     [ISSUE_WIDTH],
    output RegAddr_t                               issue_raddr1 [ISSUE_WIDTH],
    output RegAddr_t                               issue_raddr2 [ISSUE_WIDTH],
    output RegAddr_t                               issue_waddr  [ISSUE_WIDTH],
    output logic [ISSUE_WIDTH-1:0]                 issue_we,
    output logic [ISSUE_WIDTH-1:0][31:0]           issue_pc,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]       issue_accept,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]       count
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int AW = $clog2(ISSUE_WIDTH + 1);

    DecodedInst_t   queue_mem [QUEUE_DEPTH];
    DecodedInst_t   decoded   [FETCH_WIDTH];
    DecodedInst_t   head_entry;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  num_push;
    logic [CW-1:0]  push_count;
    logic [AW-1:0]  num_valid;
    logic           push_en;
    logic           blocked;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
        id_decode_one u_dec (
            .inst (fetch_inst[g]),
            .pc   (fetch_pc[g]),
            .dec  (decoded[g])
        );
    end

    // Admission is decided on the registered occupancy only, so a pop in
    // the same cycle never opens room for a push.
    assign fetch_ready = (CW'(QUEUE_DEPTH) - count) >= CW'(FETCH_WIDTH);
    assign push_en     = fetch_ready & fetch_valid[0] & ~flush;
    assign push_count  = push_en ? num_push : '0;

    // Count the valid fetch slots (they are contiguous from slot 0).
    always_comb begin
        num_push = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (fetch_valid[i]) begin
                num_push = num_push + CW'(1);
            end
        end
    end

    // Present head entries in order, stopping at the first serialising op.
    always_comb begin
        // NOTE: blocking assignments here because each slot reads the stop flag left by the previous one.
        blocked    = 1'b0;
        num_valid  = '0;
        head_entry = queue_mem[head];
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            head_entry      = queue_mem[head + PW'(i)];
            issue_valid[i]  = (CW'(i) < count) && !blocked &&
                              ((i == 0) || !is_serialising(head_entry.op));
            issue_op[i]     = head_entry.op;
            issue_raddr1[i] = head_entry.raddr1;
            issue_raddr2[i] = head_entry.raddr2;
            issue_waddr[i]  = head_entry.waddr;
            issue_we[i]     = head_entry.we;
            issue_pc[i]     = head_entry.pc;
            if (issue_valid[i]) begin
                num_valid = num_valid + AW'(1);
            end
            if (!issue_valid[i] || is_serialising(head_entry.op)) begin
                blocked = 1'b1;
            end
        end
    end

    // Pointer and occupancy state; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(issue_accept);
            tail  <= tail + PW'(push_count);
            count <= count + push_count - CW'(issue_accept);
        end
    end

    // Write decoded entries into consecutive slots starting at the tail.
    // NOTE: entry storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (fetch_valid[i]) begin
                    queue_mem[tail + PW'(i)] <= decoded[i];
                end
            end
        end
    end

    // Consuming more slots than were presented is a protocol error upstream.
    accept_within_valid : assert property (
        @(posedge clk) disable iff (rst) issue_accept <= num_valid
    );

endmodule

// File: doc/id_decode_queue.md
Name: id_decode_queue

Overview:
- Multi-way decode stage between instruction fetch and issue.
- Each cycle it accepts up to FETCH_WIDTH fetched instructions and decodes each one (SPECIAL, SPECIAL2 and COP0 subsets) into op and register fields.
- Decoded entries are stored in an in-order circular queue of QUEUE_DEPTH entries.
- Up to ISSUE_WIDTH entries are presented per cycle, with serialising ops forced to issue alone.

Parameters:
- FETCH_WIDTH, 2, instructions accepted per cycle (1..4).
- ISSUE_WIDTH, 2, entries presented per cycle (1..4, ≤ QUEUE_DEPTH).
- QUEUE_DEPTH, 8, queue entries (power of two, ≥ FETCH_WIDTH).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all queued entries.
- fetch_valid  in  FETCH_WIDTH  per-slot valid; set bits are contiguous from slot 0.
- fetch_inst  in  FETCH_WIDTH×32  instruction words.
- fetch_pc  in  FETCH_WIDTH×32  instruction addresses.
- fetch_ready  out  1  high when free entries ≥ FETCH_WIDTH.
- issue_valid  out  ISSUE_WIDTH  per-slot valid, contiguous from slot 0.
- issue_op  out  ISSUE_WIDTH×Oper_t  decoded operation.
- issue_raddr1, issue_raddr2, issue_waddr  out  ISSUE_WIDTH×RegAddr_t  register fields.
- issue_we  out  ISSUE_WIDTH  register write enable.
- issue_pc  out  ISSUE_WIDTH×32  address of each presented entry.
- issue_accept  in  $clog2(ISSUE_WIDTH+1)  number of presented slots consumed this cycle.
- count  out  $clog2(QUEUE_DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, rst=1): head=0, tail=0, count=0, issue_valid=0, fetch_ready=1. Entry storage is not reset.
- Push: occurs when fetch_ready & fetch_valid[0].
  - All set fetch_valid slots are written at tail, tail+1, … (mod QUEUE_DEPTH).
  - Push is all-or-nothing; partial acceptance never happens.
  - When fetch_ready=0, fetch inputs are ignored.
- Decode happens combinationally at push time; the queue stores decoded fields plus pc.
  - Defaults: raddr1=rs, raddr2=rt, waddr=rd, we=1.
  - inst==0 → NOP (we=0, r1=r2=0).
  - SPECIAL funct 24/25/26/27 → AND/OR/XOR/NOR.
  - SPECIAL funct 10/12 → MFHI/MFLO.
  - SPECIAL funct 11/13 → MTHI/MTLO (we=0).
  - SPECIAL funct 0B/0A → MOVN/MOVZ.
  - SPECIAL funct 08 → JR (we=0).
  - SPECIAL funct 09 → JALR.
  - SPECIAL2 funct 01 → MADDU (we=0).
  - COP0 rs=00 → MFC0 (waddr=rt, r1=r2=0).
  - COP0 rs=04 → MTC0 (we=0, r1=0).
  - COP0 rs=10 with funct 18 → ERET (we=0, r1=0).
  - Everything else → INVALID.
  - All funct/rs codes above are hex.
- Issue presentation is combinational from the queue head.
  - Slot i is valid iff i < count, and no entry at head+j for 0≤j≤i with j<i is serialising, and entry i itself is not serialising unless i=0.
  - Serialising ops are MTC0, ERET and INVALID. They only ever appear in slot 0, with issue_valid=1 in slot 0 only.
- Pop: head advances by issue_accept and count is updated. issue_accept greater than the number of valid slots is illegal; assert it in simulation.
- Simultaneous push and pop: count_next = count + pushed − popped.
  - fetch_ready is computed from the registered count only; a same-cycle pop does not enable a push.
- Pointer wrap: head and tail wrap modulo QUEUE_DEPTH. Full is count==QUEUE_DEPTH; empty is count==0.
- flush: the next cycle has count=0 and head=tail=0. Flush has priority over push and pop in the same cycle.
- Reset mid-operation discards all entries immediately. Outputs go to their reset values asynchronously.

Decomposition:
- Shared package (cpu_defs): Oper_t and its new enumerators (existing set only), RegAddr_t, the opcode/funct/COP0-rs constants, and a DecodedInst_t struct {op, raddr1, raddr2, waddr, we, pc}.
- Sub-module id_decode_one: combinational single-instruction decoder. Instantiated FETCH_WIDTH times.

Test Plan:
- Reset, then push {0x00851024 AND, 0x00000000} with issue_accept=0 → count=2; slot0 op=AND, r1=4, r2=5, waddr=2, we=1; slot1 op=NOP, we=0.
- Push {MTC0 0x40826000, OR 0x00A62025} with issue_accept=0 → slot0 valid with MTC0 (r1=0, r2=2, we=0); slot1 invalid. Accept 1 → OR appears in slot0 next cycle.
- Push 4 pairs with no pops (DEPTH=8) → count=8, fetch_ready=0; a further push is ignored. Accept 2 → count=6, fetch_ready=1 the following cycle.
- Steady state with push 2 and accept 2 each cycle over 20 cycles → pointers wrap, count constant, pcs in strict order with none lost or duplicated.
- Queue at count=5, then assert flush with fetch_valid=11 in the same cycle → next cycle count=0, issue_valid=0, no pushed entries retained.
- Assert rst asynchronously between edges while count=3 → issue_valid=0 and count=0 before the next clock edge; 0x7000_0001 pushed afterwards decodes as MADDU with we=0.
